// File: rtl/iiitb_sipo_rx.sv
// rtl/iiitb_sipo_rx.sv - serial-in parallel-out receiver paired with an upstream PISO shifter
// Optional guard-bit checking is enabled by defining SIPO_RX_GUARD_CHECK_EN.
module iiitb_sipo_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHIFT,
        HOLD
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             ovr_q;
    logic             ferr_q;
    logic             guard_err;

`ifdef SIPO_RX_GUARD_CHECK_EN
    assign guard_err = din;
`else
    assign guard_err = 1'b0;
`endif

    // Shift register with the current bit merged in, so the final edge can publish a whole word.
    always_comb begin
        shift_d        = shift_q;
        shift_d[cnt_q] = din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            if (clr_ovr) begin
                ovr_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    cnt_q <= '0;
                    if (guard_err) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ferr_q  <= 1'b1;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_d;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        data_q  <= shift_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        if (start) begin
                            state_q <= ARM;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (start) begin
                        // Unconsumed word wins; the new frame is dropped. Set overrides clr_ovr.
                        ovr_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule
